// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Handshake, register-file and ALU bundle for alu_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [5:0]  rf_raddr1;
    logic [5:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [5:0]  alu_sel;
    logic [15:0] alu_result;
    logic [31:0] mul_result;
    logic [15:0] div_result;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  instr_valid, instr, rf_rdata1, rf_rdata2,
               alu_result, mul_result, div_result,
        output instr_ready, rf_raddr1, rf_raddr2, alu_a, alu_b, alu_sel,
               rf_we, rf_waddr, rf_wdata, busy, done, err
    );

    modport slave (
        output instr_valid, instr, rf_rdata1, rf_rdata2,
               alu_result, mul_result, div_result,
        input  instr_ready, rf_raddr1, rf_raddr2, alu_a, alu_b, alu_sel,
               rf_we, rf_waddr, rf_wdata, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Multi-cycle controller sequencing one ALU instruction at a
//               time: operand read, latency wait, register-file writeback.
//               Optional macro ALU_SEQ_DIVZERO_CHECK_EN suppresses writeback
//               of a DIV whose divisor (alu_a) is zero and pulses err.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_op_sequencer_if.master seq
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WB_LO = 3'd4;
    localparam logic [2:0] S_WB_HI = 3'd5;

    localparam logic [5:0] c_OP_MUL  = 6'd3;
    localparam logic [5:0] c_OP_DIV  = 6'd4;
    localparam logic [5:0] c_OP_LAST = 6'd12;
    localparam logic [3:0] c_MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] c_DIV_CNT = 4'(DIV_LAT);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:2] r_instr;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [5:0]  r_alu_sel;
    logic [3:0]  r_cnt;
    logic        r_err;

    logic [5:0]  w_op;
    logic [5:0]  w_rdst2;
    logic [5:0]  w_rdst1;
    logic [5:0]  w_rsrc2;
    logic [5:0]  w_rsrc1;
    logic        w_legal;
    logic        w_accept;
    logic        w_divzero;

    assign w_op     = r_instr[31:26];
    assign w_rdst2  = r_instr[25:20];
    assign w_rdst1  = r_instr[19:14];
    assign w_rsrc2  = r_instr[13:8];
    assign w_rsrc1  = r_instr[7:2];
    assign w_legal  = (w_op <= c_OP_LAST);
    assign w_accept = seq.instr_valid && (r_state == S_IDLE) && !reset;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    assign w_divzero = (r_alu_sel == c_OP_DIV) && (r_alu_a == 16'h0000);
`else
    assign w_divzero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_READ;
            S_READ:  w_next_state = S_LATCH;
            S_LATCH: w_next_state = w_legal ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = w_divzero ? S_IDLE : S_WB_LO;
                end
            end
            S_WB_LO: w_next_state = (r_alu_sel == c_OP_MUL) ? S_WB_HI : S_IDLE;
            S_WB_HI: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // err is registered so its pulse lands in the first IDLE cycle after an abort
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr   <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_instr <= seq.instr[31:2];
            end
            if (r_state == S_LATCH) begin
                r_alu_a   <= seq.rf_rdata1;
                r_alu_b   <= seq.rf_rdata2;
                r_alu_sel <= w_op;
                if (w_op == c_OP_MUL) begin
                    r_cnt <= c_MUL_CNT;
                end else if (w_op == c_OP_DIV) begin
                    r_cnt <= c_DIV_CNT;
                end else begin
                    r_cnt <= 4'd1;
                end
                if (!w_legal) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
                if ((r_cnt <= 4'd1) && w_divzero) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        seq.instr_ready = (r_state == S_IDLE) && !reset;
        seq.busy        = (r_state != S_IDLE);
        seq.rf_raddr1   = 6'd0;
        seq.rf_raddr2   = 6'd0;
        seq.rf_we       = 1'b0;
        seq.rf_waddr    = 6'd0;
        seq.rf_wdata    = 16'h0000;
        seq.done        = 1'b0;
        seq.err         = r_err;
        seq.alu_a       = r_alu_a;
        seq.alu_b       = r_alu_b;
        seq.alu_sel     = r_alu_sel;
        case (r_state)
            S_READ: begin
                seq.rf_raddr1 = w_rsrc1;
                seq.rf_raddr2 = w_rsrc2;
            end
            S_WB_LO: begin
                seq.rf_we    = 1'b1;
                seq.rf_waddr = w_rdst1;
                if (r_alu_sel == c_OP_MUL) begin
                    seq.rf_wdata = seq.mul_result[15:0];
                end else if (r_alu_sel == c_OP_DIV) begin
                    seq.rf_wdata = seq.div_result;
                end else begin
                    seq.rf_wdata = seq.alu_result;
                end
                seq.done = (r_alu_sel != c_OP_MUL);
            end
            S_WB_HI: begin
                seq.rf_we    = 1'b1;
                seq.rf_waddr = w_rdst2;
                seq.rf_wdata = seq.mul_result[31:16];
                seq.done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Scoreboard bench for alu_op_sequencer with a behavioural
//               register file, ALU, multiplier and divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic        dn;
        int          at;
        logic [15:0] a;
        logic [15:0] b;
    } wb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [15:0] regs [64] = '{default: 16'h0000};
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [15:0] pre_data = 16'h0000;

    wb_t wbq [$];
    int  errq [$];

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .seq   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu_f(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            6'd0:    return a + b;
            6'd1:    return b - a;
            6'd2:    return 16'h0000 - a;
            6'd5:    return a | b;
            6'd6:    return a ^ b;
            6'd7:    return ~(a & b);
            6'd8:    return ~(a | b);
            6'd9:    return ~(a ^ b);
            6'd10:   return ~a;
            6'd11:   return a << 1;
            6'd12:   return a >> 1;
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
    assign bus.mul_result = 32'(bus.alu_a) * 32'(bus.alu_b);
    assign bus.div_result = (bus.alu_a == 16'h0000) ? 16'hFFFF : bus.alu_b / bus.alu_a;

    always @(posedge clk) begin
        bus.rf_rdata1 <= regs[bus.rf_raddr1];
        bus.rf_rdata2 <= regs[bus.rf_raddr2];
        if (pre_we) begin
            regs[pre_addr] <= pre_data;
        end else if (bus.rf_we) begin
            regs[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rf_we) begin
            if (wbq.size() == 0) begin
                check("unexpected_we", bus.rf_we, 1'b0);
            end else begin
                wb_t e;
                e = wbq.pop_front();
                check("wb_addr", bus.rf_waddr, e.addr);
                check("wb_data", bus.rf_wdata, e.data);
                check("wb_done", bus.done, e.dn);
                check("wb_cycle", cyc, e.at);
                check("alu_a_hold", bus.alu_a, e.a);
                check("alu_b_hold", bus.alu_b, e.b);
            end
        end else if (bus.done) begin
            check("done_without_we", bus.done, 1'b0);
        end
        if (bus.err) begin
            if (errq.size() == 0) check("unexpected_err", bus.err, 1'b0);
            else                  check("err_cycle", cyc, errq.pop_front());
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] rd2, input logic [5:0] rd1,
                                       input logic [5:0] rs2, input logic [5:0] rs1);
        return {op, rd2, rd1, rs2, rs1, 2'b00};
    endfunction

    task automatic set_reg(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // t is the IDLE cycle in which the handshake is seen
    task automatic wait_accept(output int t);
        int k;
        t = -1;
        for (k = 0; k < 40; k++) begin
            if (bus.instr_ready && bus.instr_valid) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            check("accept_timeout", bus.instr_ready, 1'b1);
            t = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [31:0] ins, input int t);
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        op = ins[31:26];
        a  = regs[ins[7:2]];
        b  = regs[ins[13:8]];
        if (op > 6'd12) begin
            errq.push_back(t + 3);
        end else if (op == 6'd3) begin
            p = 32'(a) * 32'(b);
            wbq.push_back('{ins[19:14], p[15:0], 1'b0, t + 3 + MUL_LAT, a, b});
            wbq.push_back('{ins[25:20], p[31:16], 1'b1, t + 4 + MUL_LAT, a, b});
        end else if (op == 6'd4) begin
            if (a == 16'h0000) begin
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
                errq.push_back(t + 3 + DIV_LAT);
`else
                wbq.push_back('{ins[19:14], 16'hFFFF, 1'b1, t + 3 + DIV_LAT, a, b});
`endif
            end else begin
                wbq.push_back('{ins[19:14], b / a, 1'b1, t + 3 + DIV_LAT, a, b});
            end
        end else begin
            wbq.push_back('{ins[19:14], alu_f(op, a, b), 1'b1, t + 4, a, b});
        end
    endtask

    task automatic issue(input logic [31:0] ins, input bit do_push, output int t);
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        wait_accept(t);
        bus.instr_valid = 1'b0;
        if (do_push) push_expect(ins, t);
        @(negedge clk);
        check("raddr1", bus.rf_raddr1, ins[7:2]);
        check("raddr2", bus.rf_raddr2, ins[13:8]);
    endtask

    initial begin
        int t;
        int t1;
        int t2;
        logic [31:0] ins;
        logic [5:0] ops [10] = '{6'd1, 6'd2, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};

        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        set_reg(6'd1, 16'h0003);
        set_reg(6'd2, 16'h0005);
        @(negedge clk);
        check("rst_ready", bus.instr_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_we", bus.rf_we, 1'b0);
        check("rst_waddr", bus.rf_waddr, 6'd0);
        check("rst_wdata", bus.rf_wdata, 16'h0);
        check("rst_raddr1", bus.rf_raddr1, 6'd0);
        check("rst_alu_a", bus.alu_a, 16'h0);
        check("rst_alu_sel", bus.alu_sel, 6'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.instr_ready, 1'b1);

        // ADD R7 = R1 + R2
        issue(mk(6'd0, 6'd0, 6'd7, 6'd2, 6'd1), 1'b1, t);
        check("add_busy", bus.busy, 1'b1);
        while (cyc < t + 4) @(negedge clk);
        check("add_ready_in_wb", bus.instr_ready, 1'b0);
        @(negedge clk);
        check("add_ready_after", bus.instr_ready, 1'b1);
        check("add_r7", regs[7], 16'h0008);

        // MUL R9:R8 = R1 * R2
        set_reg(6'd1, 16'h1234);
        set_reg(6'd2, 16'h0100);
        issue(mk(6'd3, 6'd9, 6'd8, 6'd2, 6'd1), 1'b1, t);

        // remaining single-cycle ops
        set_reg(6'd5, 16'hA5C3);
        set_reg(6'd6, 16'h0F0F);
        for (int i = 0; i < 10; i++) begin
            issue(mk(ops[i], 6'd0, 6'(20 + i), 6'd6, 6'd5), 1'b1, t);
        end

        // DIV normal and by zero
        set_reg(6'd3, 16'd4);
        set_reg(6'd4, 16'd100);
        set_reg(6'd10, 16'h0000);
        set_reg(6'd2, 16'h0010);
        issue(mk(6'd4, 6'd0, 6'd11, 6'd4, 6'd3), 1'b1, t);
        issue(mk(6'd4, 6'd0, 6'd12, 6'd2, 6'd10), 1'b1, t);

        // illegal opcode
        issue(mk(6'h3F, 6'd0, 6'd13, 6'd2, 6'd1), 1'b1, t);
        while (cyc < t + 3) @(negedge clk);
        check("illegal_ready", bus.instr_ready, 1'b1);

        // destination equals source
        issue(mk(6'd0, 6'd0, 6'd3, 6'd4, 6'd3), 1'b1, t);

        // back-to-back ADDs with instr_valid held high
        set_reg(6'd1, 16'h1111);
        set_reg(6'd2, 16'h2222);
        @(negedge clk);
        ins             = mk(6'd0, 6'd0, 6'd14, 6'd2, 6'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        wait_accept(t1);
        push_expect(ins, t1);
        ins       = mk(6'd6, 6'd0, 6'd15, 6'd6, 6'd5);
        bus.instr = ins;
        wait_accept(t2);
        bus.instr_valid = 1'b0;
        push_expect(ins, t2);
        check("b2b_gap", t2 - t1, 5);

        // reset during DIV wait, then a normal ADD
        issue(mk(6'd4, 6'd0, 6'd16, 6'd4, 6'd3), 1'b0, t);
        while (cyc < t + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_busy", bus.busy, 1'b0);
        check("rst_wait_ready", bus.instr_ready, 1'b0);
        check("rst_wait_we", bus.rf_we, 1'b0);
        check("rst_wait_alu_a", bus.alu_a, 16'h0);
        check("rst_wait_alu_b", bus.alu_b, 16'h0);
        check("rst_wait_sel", bus.alu_sel, 6'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_wait_ready_after", bus.instr_ready, 1'b1);
        issue(mk(6'd0, 6'd0, 6'd17, 6'd2, 6'd1), 1'b1, t);

        repeat (30) @(negedge clk);
        check("r16_untouched", regs[16], 16'h0000);
        check("wbq_empty", wbq.size(), 0);
        check("errq_empty", errq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
